// File: rtl/mult_datapath_if.sv
// Control/status bundle for the shift-add multiplier datapath.
// Latency: none (wires only).
// Backpressure: none; the master sequences controls cycle by cycle.
interface mult_datapath_if #(
  parameter int WIDTH = 32
);
  logic                 load;
  logic [WIDTH-1:0]     multiplicand_in;
  logic [WIDTH-1:0]     multiplier_in;
  logic                 add_product;
  logic                 shift_right;
  logic                 write;
  logic                 product_0;
  logic                 is_32;
  logic [2*WIDTH-1:0]   result;
  logic                 done;

  // Sequencer side: drives operands and per-cycle controls, watches status.
  modport master (
    output load, multiplicand_in, multiplier_in, add_product, shift_right, write,
    input  product_0, is_32, result, done
  );

  // Datapath side.
  modport slave (
    input  load, multiplicand_in, multiplier_in, add_product, shift_right, write,
    output product_0, is_32, result, done
  );
endinterface

// File: rtl/mult_datapath.sv
// Unsigned shift-add multiplier datapath; an external sequencer issues the controls.
// Latency: one cycle per iteration, WIDTH iterations, result/done one cycle after write.
// Backpressure: none; iteration controls are ignored once the counter saturates at WIDTH.
// Optional macro MULT_DATAPATH_ITER_OUT_EN exposes the iteration counter as iter_cnt.
module mult_datapath #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 Clr,
  mult_datapath_if.slave       bus
`ifdef MULT_DATAPATH_ITER_OUT_EN
  ,
  output logic [$clog2(WIDTH):0] iter_cnt
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic               carry_q,  carry_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q,   done_d;

  logic [WIDTH:0]     sum;
  logic               sat;

  // High half plus multiplicand, one bit wider so the carry is never lost.
  assign sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign sat = (cnt_q == WIDTH_C);

  // Next-state: load wins over iteration controls; saturated counter freezes the product.
  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    if (bus.load) begin
      mcand_d = bus.multiplicand_in;
      prod_d  = {{WIDTH{1'b0}}, bus.multiplier_in};
      carry_d = 1'b0;
      cnt_d   = '0;
    end else if (!sat) begin
      if (bus.add_product && bus.shift_right) begin
        // Shift the post-add value in the same cycle: {sum, low} >> 1.
        prod_d  = {sum, prod_q[WIDTH-1:1]};
        carry_d = 1'b0;
        cnt_d   = cnt_q + ONE_C;
      end else if (bus.add_product) begin
        prod_d  = {sum[WIDTH-1:0], prod_q[WIDTH-1:0]};
        carry_d = sum[WIDTH];
      end else if (bus.shift_right) begin
        prod_d  = {carry_q, prod_q[2*WIDTH-1:1]};
        carry_d = 1'b0;
        cnt_d   = cnt_q + ONE_C;
      end
    end

    // Commit captures the product as held before this edge, even alongside load.
    if (bus.write) begin
      result_d = prod_q;
      done_d   = 1'b1;
    end
  end

  // State registers with synchronous clear overriding every control.
  always_ff @(posedge clk) begin
    if (Clr) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.product_0 = prod_q[0];
  assign bus.is_32     = sat;
  assign bus.result    = result_q;
  assign bus.done      = done_q;

`ifdef MULT_DATAPATH_ITER_OUT_EN
  assign iter_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: reset, full multiplies, saturation, abort, write+load.
// Latency: drives inputs and samples outputs 1 time unit after each rising edge.
// Backpressure: none.
module tb_mult_datapath;
  localparam int WIDTH = 32;

  logic clk;
  logic Clr;
  int   checks;
  int   failures;

  mult_datapath_if #(.WIDTH(WIDTH)) bus ();

`ifdef MULT_DATAPATH_ITER_OUT_EN
  logic [$clog2(WIDTH):0] iter_cnt;
  mult_datapath #(.WIDTH(WIDTH)) dut (.clk(clk), .Clr(Clr), .bus(bus), .iter_cnt(iter_cnt));
`else
  mult_datapath #(.WIDTH(WIDTH)) dut (.clk(clk), .Clr(Clr), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Clr                 = 1'b0;
    bus.load            = 1'b0;
    bus.add_product     = 1'b0;
    bus.shift_right     = 1'b0;
    bus.write           = 1'b0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    idle();
    bus.multiplicand_in = a;
    bus.multiplier_in   = b;
    bus.load            = 1'b1;
    cycle();
    idle();
  endtask

  // Standard algorithm step: add when product_0 is set, shift every cycle.
  task automatic iterate(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      bus.add_product = bus.product_0;
      bus.shift_right = 1'b1;
      cycle();
    end
    idle();
  endtask

  task automatic do_write();
    idle();
    bus.write = 1'b1;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    bus.multiplicand_in = 32'hDEAD_BEEF;
    bus.multiplier_in   = 32'h1234_5678;
    Clr = 1'b1; bus.load = 1'b1; bus.add_product = 1'b1;
    bus.shift_right = 1'b1; bus.write = 1'b1;
    cycle();
    idle();
    checks++; if (bus.result !== 64'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.is_32 !== 1'b0) begin failures++; $display("FAIL reset_is32 got=%b exp=0", bus.is_32); end
    checks++; if (bus.product_0 !== 1'b0) begin failures++; $display("FAIL reset_p0 got=%b exp=0", bus.product_0); end
`ifdef MULT_DATAPATH_ITER_OUT_EN
    checks++; if (iter_cnt !== '0) begin failures++; $display("FAIL reset_iter got=%0d exp=0", iter_cnt); end
`endif
  endtask

  task automatic test_3x5();
    do_load(32'd3, 32'd5);
    checks++; if (bus.product_0 !== 1'b1) begin failures++; $display("FAIL p0_after_load got=%b exp=1", bus.product_0); end
    iterate(31);
    checks++; if (bus.is_32 !== 1'b0) begin failures++; $display("FAIL is32_at31 got=%b exp=0", bus.is_32); end
    iterate(1);
    checks++; if (bus.is_32 !== 1'b1) begin failures++; $display("FAIL is32_at32 got=%b exp=1", bus.is_32); end
`ifdef MULT_DATAPATH_ITER_OUT_EN
    checks++; if (iter_cnt !== 6'd32) begin failures++; $display("FAIL iter_at32 got=%0d exp=32", iter_cnt); end
`endif
    do_write();
    checks++; if (bus.result !== 64'h0000_0000_0000_000F) begin failures++; $display("FAIL result_3x5 got=%h exp=f", bus.result); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b exp=1", bus.done); end
    cycle();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_clear got=%b exp=0", bus.done); end
  endtask

  task automatic test_saturate();
    // Continues from the finished 3 x 5 multiply.
    for (int i = 0; i < 3; i++) begin
      bus.add_product = 1'b1;
      bus.shift_right = 1'b1;
      cycle();
    end
    idle();
    checks++; if (bus.is_32 !== 1'b1) begin failures++; $display("FAIL sat_is32 got=%b exp=1", bus.is_32); end
`ifdef MULT_DATAPATH_ITER_OUT_EN
    checks++; if (iter_cnt !== 6'd32) begin failures++; $display("FAIL sat_iter got=%0d exp=32", iter_cnt); end
`endif
    do_write();
    checks++; if (bus.result !== 64'h0000_0000_0000_000F) begin failures++; $display("FAIL sat_product got=%h exp=f", bus.result); end
  endtask

  task automatic test_ffff();
    do_load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    iterate(32);
    do_write();
    checks++; if (bus.result !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL result_ffff got=%h exp=fffffffe00000001", bus.result); end
  endtask

  task automatic test_add_only_carry();
    // Separate add then shift must route the carry into bit 2W-1: 0xFFFFFFFF*1 first step.
    do_load(32'hFFFF_FFFF, 32'h0000_0003);
    bus.add_product = 1'b1; cycle();            // high = FFFFFFFF, carry 0
    bus.add_product = 1'b1; cycle();            // high = FFFFFFFE, carry 1
    idle(); bus.shift_right = 1'b1; cycle();    // product = {1, FFFFFFFE, 00000003} >> 1
    idle();
    do_write();
    checks++; if (bus.result !== 64'hFFFF_FFFF_0000_0001) begin failures++; $display("FAIL carry_shift got=%h exp=ffffffff00000001", bus.result); end
  endtask

  task automatic test_clr_mid();
    do_load(32'd7, 32'd9);
    iterate(10);
    Clr = 1'b1; bus.load = 1'b1; bus.add_product = 1'b1;
    bus.shift_right = 1'b1; bus.write = 1'b1;
    cycle();
    idle();
    checks++; if (bus.result !== 64'h0) begin failures++; $display("FAIL clr_result got=%h exp=0", bus.result); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL clr_done got=%b exp=0", bus.done); end
    checks++; if (bus.is_32 !== 1'b0) begin failures++; $display("FAIL clr_is32 got=%b exp=0", bus.is_32); end
    do_write();
    checks++; if (bus.result !== 64'h0) begin failures++; $display("FAIL clr_product got=%h exp=0", bus.result); end
    do_load(32'd7, 32'd9);
    iterate(32);
    do_write();
    checks++; if (bus.result !== 64'd63) begin failures++; $display("FAIL result_7x9 got=%h exp=3f", bus.result); end
  endtask

  task automatic test_write_load();
    do_load(32'd6, 32'd7);
    iterate(32);
    idle();
    bus.multiplicand_in = 32'd11;
    bus.multiplier_in   = 32'h0000_00A5;
    bus.load  = 1'b1;
    bus.write = 1'b1;
    cycle();
    idle();
    checks++; if (bus.result !== 64'd42) begin failures++; $display("FAIL wl_result got=%h exp=2a", bus.result); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL wl_done got=%b exp=1", bus.done); end
    checks++; if (bus.is_32 !== 1'b0) begin failures++; $display("FAIL wl_is32 got=%b exp=0", bus.is_32); end
`ifdef MULT_DATAPATH_ITER_OUT_EN
    checks++; if (iter_cnt !== '0) begin failures++; $display("FAIL wl_iter got=%0d exp=0", iter_cnt); end
`endif
    do_write();
    checks++; if (bus.result !== 64'h0000_0000_0000_00A5) begin failures++; $display("FAIL wl_low_half got=%h exp=a5", bus.result); end
    iterate(31);
    checks++; if (bus.is_32 !== 1'b0) begin failures++; $display("FAIL wl_is32_31 got=%b exp=0", bus.is_32); end
    iterate(1);
    do_write();
    checks++; if (bus.result !== 64'd1815) begin failures++; $display("FAIL result_11xa5 got=%h exp=717", bus.result); end
  endtask

  task automatic test_back_to_back();
    do_load(32'h8000_0001, 32'h0001_0000);
    iterate(32);
    do_write();
    do_load(32'd0, 32'hFFFF_FFFF);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b exp=0", bus.done); end
    iterate(32);
    checks++; if (bus.result !== 64'h0000_8000_0001_0000) begin failures++; $display("FAIL b2b_first got=%h exp=0000800000010000", bus.result); end
    do_write();
    checks++; if (bus.result !== 64'h0) begin failures++; $display("FAIL b2b_zero got=%h exp=0", bus.result); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    bus.multiplicand_in = '0;
    bus.multiplier_in   = '0;
    cycle();
    test_reset();
    test_3x5();
    test_saturate();
    test_ffff();
    test_add_only_carry();
    test_clr_mid();
    test_write_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
